alu_seq: RTL

//   Parametrised, registered multi-cycle ALU that succeeds the 8-bit combinational ALU.

---
 rtl/alu_seq.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with valid/ready handshakes on both sides; shifts run one bit per cycle.
// Optional unsigned shift-add multiplier on operator 4'b1000 when ALU_MUL_EN is defined.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       operator,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             s_flag,
    output logic             c_flag,
    output logic             z_flag,
    output logic             ov_flag,
    output logic             busy
);

    localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CW  = SHW + 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_LSL = 4'b0110;
    localparam logic [3:0] OP_LSR = 4'b0111;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;

    logic [WIDTH-1:0] r_res;
    logic             r_s;
    logic             r_c;
    logic             r_z;
    logic             r_ov;
    logic [3:0]       r_opc;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_multi;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res1;
    logic             w_c1;
    logic             w_ov1;
    logic [WIDTH-1:0] w_ex_res;
    logic             w_ex_c;
    logic             w_ex_ov;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod_nx;
`endif

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_EXEC);
    assign res       = r_res;
    assign s_flag    = r_s;
    assign c_flag    = r_c;
    assign z_flag    = r_z;
    assign ov_flag   = r_ov;

    // Single-cycle result from the live operands, and one step of the multi-cycle engine.
    always_comb begin
        w_amt    = op2[SHW-1:0];
        w_add    = {1'b0, op1} + {1'b0, op2};
        w_sub    = {1'b0, op1} - {1'b0, op2};
        w_res1   = '0;
        w_c1     = 1'b0;
        w_ov1    = 1'b0;
        w_multi  = 1'b0;
        w_ex_res = '0;
        w_ex_c   = 1'b0;
        w_ex_ov  = 1'b0;
`ifdef ALU_MUL_EN
        w_sum     = '0;
        w_prod_nx = '0;
`endif
        case (operator)
            OP_ADD: begin
                w_res1 = w_add[WIDTH-1:0];
                w_c1   = w_add[WIDTH];
                w_ov1  = (op1[WIDTH-1] == op2[WIDTH-1]) & (w_add[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SUB: begin
                w_res1 = w_sub[WIDTH-1:0];
                w_c1   = w_sub[WIDTH];
                w_ov1  = (op1[WIDTH-1] != op2[WIDTH-1]) & (w_sub[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_AND: w_res1 = op1 & op2;
            OP_OR:  w_res1 = op1 | op2;
            OP_XOR: w_res1 = op1 ^ op2;
            OP_NOT: w_res1 = ~op1;
            // A zero shift amount completes immediately with the operand unchanged.
            OP_LSL, OP_LSR: begin
                w_res1  = op1;
                w_multi = (w_amt != '0);
            end
`ifdef ALU_MUL_EN
            OP_MUL: w_multi = 1'b1;
`endif
            default: w_res1 = '0;
        endcase

        case (r_opc)
            OP_LSL: begin
                w_ex_res = {r_res[WIDTH-2:0], 1'b0};
                w_ex_c   = r_res[WIDTH-1];
            end
            OP_LSR: begin
                w_ex_res = {1'b0, r_res[WIDTH-1:1]};
                w_ex_c   = r_res[0];
            end
`ifdef ALU_MUL_EN
            // Product register: {high, low/multiplier}; add multiplicand to high on LSB, shift right.
            OP_MUL: begin
                w_sum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
                w_prod_nx = {w_sum, r_prod[WIDTH-1:1]};
                w_ex_res  = w_prod_nx[WIDTH-1:0];
                w_ex_c    = |w_prod_nx[2*WIDTH-1:WIDTH];
                w_ex_ov   = |w_prod_nx[2*WIDTH-1:WIDTH];
            end
`endif
            default: w_ex_res = r_res;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = w_multi ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_state_nx = w_multi ? S_EXEC : S_DONE;
                end else if (out_ready) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Result/flag registers: loaded on accept, stepped in EXEC, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
            r_s   <= 1'b0;
            r_c   <= 1'b0;
            r_z   <= 1'b0;
            r_ov  <= 1'b0;
            r_opc <= '0;
            r_cnt <= '0;
`ifdef ALU_MUL_EN
            r_prod  <= '0;
            r_mcand <= '0;
`endif
        end else if (w_accept) begin
            r_opc <= operator;
            r_res <= w_res1;
            r_c   <= w_c1;
            r_ov  <= w_ov1;
            r_s   <= w_res1[WIDTH-1];
            r_z   <= (w_res1 == '0);
            r_cnt <= CW'(w_amt);
`ifdef ALU_MUL_EN
            if (operator == OP_MUL) begin
                r_cnt   <= CW'(WIDTH);
                r_prod  <= {WIDTH'(0), op2};
                r_mcand <= op1;
            end
`endif
        end else if (r_state == S_EXEC) begin
            r_res <= w_ex_res;
            r_c   <= w_ex_c;
            r_ov  <= w_ex_ov;
            r_s   <= w_ex_res[WIDTH-1];
            r_z   <= (w_ex_res == '0);
            r_cnt <= r_cnt - CW'(1);
`ifdef ALU_MUL_EN
            r_prod <= w_prod_nx;
`endif
        end
    end

endmodule
